// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative signed multiply/divide engine.
package multdiv_pkg;

  localparam int DATA_W = 32;
  localparam int ITER_N = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    mag = v[DATA_W-1] ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/multdiv_iter_cnt.sv
// Iteration counter for the multdiv engine: synchronous clear, count enable,
// terminal flag on the last iteration.
module multdiv_iter_cnt
  import multdiv_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count_r;

  // Iteration count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == CNT_W'(ITER_N - 1));

endmodule

// File: rtl/multdiv_engine.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) on operand
// magnitudes with sign fix-up at completion. MULTDIV_EARLY_EXC_EN: divide by
// zero completes straight from the capture edge instead of running 32 steps.
module multdiv_engine
  import multdiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY
);

  state_e              state_r, state_nx_s;
  logic [2*DATA_W-1:0] work_r, work_nx_s;
  logic [DATA_W-1:0]   opb_r, opb_nx_s;
  logic                neg_r, neg_nx_s;
  logic                dz_r, dz_nx_s;
  logic [DATA_W-1:0]   result_r, result_nx_s;
  logic                exc_r, exc_nx_s;
  logic                rdy_r, rdy_nx_s;
  logic                cnt_clr_s, cnt_en_s, cnt_tc_s;

  logic [DATA_W:0]     step_sum_s;
  logic [2*DATA_W-1:0] mul_step_s, prod_s;
  logic                mul_ovf_s;
  logic [DATA_W:0]     rem_sh_s;
  logic                rem_ge_s;
  logic [DATA_W-1:0]   rem_sub_s;
  logic [2*DATA_W-1:0] div_step_s;
  logic [DATA_W-1:0]   quo_s;

  multdiv_iter_cnt u_iter_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (cnt_clr_s),
    .enable   (cnt_en_s),
    .terminal (cnt_tc_s)
  );

  // work_r holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign step_sum_s = {1'b0, work_r[2*DATA_W-1:DATA_W]} + (work_r[0] ? {1'b0, opb_r} : {(DATA_W+1){1'b0}});
  assign mul_step_s = {step_sum_s, work_r[DATA_W-1:1]};
  assign prod_s     = neg_r ? (~mul_step_s + {{(2*DATA_W-1){1'b0}}, 1'b1}) : mul_step_s;
  assign mul_ovf_s  = (prod_s[2*DATA_W-1:DATA_W] != {DATA_W{prod_s[DATA_W-1]}});

  assign rem_sh_s   = work_r[2*DATA_W-1:DATA_W-1];
  assign rem_ge_s   = (rem_sh_s >= {1'b0, opb_r});
  assign rem_sub_s  = rem_sh_s[DATA_W-1:0] - opb_r;
  assign div_step_s = rem_ge_s ? {rem_sub_s, work_r[DATA_W-2:0], 1'b1}
                               : {rem_sh_s[DATA_W-1:0], work_r[DATA_W-2:0], 1'b0};
  assign quo_s      = neg_r ? (~div_step_s[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, 1'b1})
                            : div_step_s[DATA_W-1:0];

  // Next-state, datapath step and completion result selection.
  always_comb begin
    state_nx_s  = state_r;
    work_nx_s   = work_r;
    opb_nx_s    = opb_r;
    neg_nx_s    = neg_r;
    dz_nx_s     = dz_r;
    result_nx_s = result_r;
    exc_nx_s    = exc_r;
    rdy_nx_s    = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;
    if (ctrl_MULT) begin
      state_nx_s = MUL;
      work_nx_s  = {{DATA_W{1'b0}}, mag(data_operandB)};
      opb_nx_s   = mag(data_operandA);
      neg_nx_s   = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
      dz_nx_s    = 1'b0;
      cnt_clr_s  = 1'b1;
    end else if (ctrl_DIV) begin
      state_nx_s = DIV;
      work_nx_s  = {{DATA_W{1'b0}}, mag(data_operandA)};
      opb_nx_s   = mag(data_operandB);
      neg_nx_s   = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
      dz_nx_s    = (data_operandB == {DATA_W{1'b0}});
      cnt_clr_s  = 1'b1;
`ifdef MULTDIV_EARLY_EXC_EN
      if (data_operandB == {DATA_W{1'b0}}) begin
        state_nx_s  = DONE;
        result_nx_s = {DATA_W{1'b0}};
        exc_nx_s    = 1'b1;
        rdy_nx_s    = 1'b1;
      end else begin
        state_nx_s  = DIV;
      end
`endif
    end else begin
      case (state_r)
        MUL: begin
          cnt_en_s  = 1'b1;
          work_nx_s = mul_step_s;
          if (cnt_tc_s) begin
            state_nx_s  = DONE;
            result_nx_s = prod_s[DATA_W-1:0];
            exc_nx_s    = mul_ovf_s;
            rdy_nx_s    = 1'b1;
          end else begin
            state_nx_s  = MUL;
          end
        end
        DIV: begin
          cnt_en_s  = 1'b1;
          work_nx_s = div_step_s;
          if (cnt_tc_s) begin
            state_nx_s  = DONE;
            // Only |0x80000000| / 1 with matching signs yields a positive 2^31.
            result_nx_s = dz_r ? {DATA_W{1'b0}} : quo_s;
            exc_nx_s    = dz_r | (~neg_r & div_step_s[DATA_W-1]);
            rdy_nx_s    = 1'b1;
          end else begin
            state_nx_s  = DIV;
          end
        end
        DONE:    state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      work_r   <= {(2*DATA_W){1'b0}};
      opb_r    <= {DATA_W{1'b0}};
      neg_r    <= 1'b0;
      dz_r     <= 1'b0;
      result_r <= {DATA_W{1'b0}};
      exc_r    <= 1'b0;
      rdy_r    <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      work_r   <= work_nx_s;
      opb_r    <= opb_nx_s;
      neg_r    <= neg_nx_s;
      dz_r     <= dz_nx_s;
      result_r <= result_nx_s;
      exc_r    <= exc_nx_s;
      rdy_r    <= rdy_nx_s;
    end
  end

  assign data_result    = result_r;
  assign data_exception = exc_r;
  assign data_resultRDY = rdy_r;

endmodule

// File: doc/multdiv_engine.md
MULTDIV_ENGINE -- requirements
Module: multdiv_engine

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: data_operandA  in  32  signed multiplicand / dividend.
REQ-004 SHALL have port: data_operandB  in  32  signed multiplier / divisor.
REQ-005 SHALL have port: ctrl_MULT  in  1  one-cycle start pulse for a multiply.
REQ-006 SHALL have port: ctrl_DIV  in  1  one-cycle start pulse for a divide.
REQ-007 SHALL have port: data_result  out  32  registered result.
REQ-008 SHALL have port: data_exception  out  1  registered exception flag, valid with data_resultRDY.
REQ-009 SHALL have port: data_resultRDY  out  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-011 SHALL, on the edge where ctrl_MULT=1, capture both operands, clear the iteration counter to 0, and enter MUL; where ctrl_DIV=1 (and ctrl_MULT=0), the same, entering DIV.
REQ-012 SHALL give ctrl_MULT priority when both start pulses are high on the same edge.
REQ-013 SHALL accept a start pulse in any state, aborting any operation in progress and restarting with the newly captured operands; the aborted operation produces no data_resultRDY.
REQ-014 SHALL perform one radix-2 iteration per cycle in MUL/DIV, 32 iterations, entering DONE on the edge that completes iteration 31.
REQ-015 SHALL assert data_resultRDY for exactly the cycle in DONE, i.e. the cycle after edge N+32 for a start on edge N, then return to IDLE.
REQ-016 SHALL compute multiply as the low 32 bits of the signed 64-bit product; data_exception=1 when the 64-bit product is not representable in signed 32 bits.
REQ-017 SHALL compute divide as the signed quotient truncated toward zero, remainder discarded.
REQ-018 SHALL, for divisor 0, return data_result=0 and data_exception=1.
REQ-019 SHALL, for 0x80000000 / 0xFFFFFFFF, return data_result=0x80000000 and data_exception=1.
REQ-020 SHALL update data_result and data_exception only on entry to DONE, holding them until the next completion.
REQ-021 SHALL ignore operand changes after the capture edge.

Reset
REQ-022 SHALL, while reset_n=0, force state IDLE, counter 0, data_result=0, data_exception=0, and data_resultRDY=0, regardless of clock.
REQ-023 SHALL abandon any in-flight operation on reset with no data_resultRDY pulse; start pulses are ignored while reset_n=0.

Configuration
REQ-024 SHALL, with MULTDIV_EARLY_EXC_EN defined, enter DONE directly from the capture edge for a divide by zero, asserting data_resultRDY in the cycle after edge N with result 0 and exception 1.
REQ-025 SHALL, without MULTDIV_EARLY_EXC_EN, run a divide by zero the full 32 iterations with the timing of REQ-015.

Structure
REQ-026 SHALL place the state enum, data width (32), and iteration count (32) in shared package multdiv_pkg.
REQ-027 SHALL implement the 5-bit iteration counter, with clear and terminal-count output, as sub-module multdiv_iter_cnt.

Verification
REQ-028 SHALL cover: MULT 7 x -6 pulsed on edge N -> data_resultRDY only in the cycle after edge N+32, result 0xFFFFFFD6, exception 0.
REQ-029 SHALL cover: MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-030 SHALL cover: DIV -7 / 2 -> result 0xFFFFFFFD, exception 0; DIV 0x80000000 / -1 -> result 0x80000000, exception 1.
REQ-031 SHALL cover: DIV 5 / 0 -> result 0, exception 1; RDY after edge N+32 without the macro, after edge N with it.
REQ-032 SHALL cover: DIV 100 / 7 started, MULT 3 x 4 pulsed 10 cycles later -> exactly one RDY, 32 cycles after the MULT pulse, result 12.
REQ-033 SHALL cover: reset_n low mid-MULT between edges -> outputs 0 immediately, no RDY after release; both ctrl pulses together with 6 and 2 -> result 12.
